herc_ctrl: RTL and testbench

HERC_CTRL -- requirements
Module: herc_ctrl

---
 rtl/herc_ctrl_if.sv | 23 ++
 rtl/herc_ctrl.sv | 161 ++++++++++++++++
 tb/tb_herc_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/herc_ctrl_if.sv
// ISA-side bus bundle for the Hercules-compatible display controller.
// The card is the slave: it samples address/data/strobes and drives read data.
interface herc_ctrl_if;
  logic [19:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_out;
  logic        bus_dir;

  modport master (
    output bus_a, bus_d, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen,
    input  bus_out, bus_dir
  );

  modport slave (
    input  bus_a, bus_d, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen,
    output bus_out, bus_dir
  );
endinterface

// File: rtl/herc_ctrl.sv
// Hercules/MDA-compatible control block: I/O and memory decode, mode and
// config registers, synchronised write strobes, status readback and the
// frame-based cursor/character blink generators.
module herc_ctrl #(
  parameter logic [11:0] IO_BASE       = 12'h3B0,
  parameter int          HGC_EN        = 1,
  parameter int          CURSOR_FRAMES = 16,
  parameter int          CHAR_FRAMES   = 32,
  parameter logic [7:0]  CTRL_INIT     = 8'h28
) (
  input  logic        clk,
  input  logic        reset,
  herc_ctrl_if.slave  bus,
  input  logic [7:0]  crtc_dout,
  input  logic [7:0]  vram_dout,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        video_in,
  output logic        crtc_cs,
  output logic        vram_cs,
  output logic [15:0] vram_addr,
  output logic        io_wr,
  output logic        mem_wr,
  output logic        graphics,
  output logic        disp_page,
  output logic        video_enabled,
  output logic        blink_enabled,
  output logic        cursor_blink,
  output logic        char_blink,
  output logic        hsync_out
);

  localparam bit          HGC_ON    = (HGC_EN != 0);
  localparam logic [19:0] BASE      = {8'h00, IO_BASE};
  localparam logic [19:0] MODE_ADDR = BASE + 20'h8;
  localparam logic [19:0] STAT_ADDR = BASE + 20'hA;
  localparam logic [19:0] CFG_ADDR  = BASE + 20'hF;
  localparam int          CUR_W     = $clog2(CURSOR_FRAMES);
  localparam int          CHR_W     = $clog2(CHAR_FRAMES);
  localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(CURSOR_FRAMES - 1);
  localparam logic [CUR_W-1:0] CUR_HALF = CUR_W'(CURSOR_FRAMES / 2);
  localparam logic [CHR_W-1:0] CHR_LAST = CHR_W'(CHAR_FRAMES - 1);
  localparam logic [CHR_W-1:0] CHR_HALF = CHR_W'(CHAR_FRAMES / 2);

  logic [7:0]       mode_reg;
  logic [1:0]       cfg_reg;
  logic [2:0]       iow_sync_reg, memw_sync_reg, vsync_sync_reg;
  logic [1:0]       ior_sync_reg, memr_sync_reg;
  logic [1:0]       settle_reg;
  logic             iow_armed_reg, memw_armed_reg;
  logic             io_wr_reg, mem_wr_reg;
  logic [CUR_W-1:0] cur_cnt_reg, cur_cnt_next;
  logic [CHR_W-1:0] chr_cnt_reg, chr_cnt_next;
  logic             cursor_blink_reg, char_blink_reg;
  logic             status_cs, mode_cs, cfg_cs;
  logic             iow_fall, memw_fall, vsync_rise;
  logic [7:0]       status_byte;

  // Address decode; I/O only when the DMA controller does not own the bus.
  assign crtc_cs   = ~bus.bus_aen & (bus.bus_a[19:3] == BASE[19:3]);
  assign mode_cs   = ~bus.bus_aen & (bus.bus_a == MODE_ADDR);
  assign status_cs = ~bus.bus_aen & (bus.bus_a == STAT_ADDR);
  assign cfg_cs    = HGC_ON & ~bus.bus_aen & (bus.bus_a == CFG_ADDR);
  assign vram_cs   = (bus.bus_a[19:16] == 4'hB) & (~bus.bus_a[15] | cfg_reg[1]);
  assign vram_addr = {bus.bus_a[15] & cfg_reg[1], bus.bus_a[14:0]};

  // A strobe is armed only after a bus-derived idle level has been seen, so a
  // strobe already low when reset releases never produces a write. A cycle
  // with both read and write strobes low is not a valid cycle and is ignored.
  assign iow_fall   = iow_armed_reg & iow_sync_reg[2] & ~iow_sync_reg[1] & ior_sync_reg[1];
  assign memw_fall  = memw_armed_reg & memw_sync_reg[2] & ~memw_sync_reg[1] & memr_sync_reg[1];
  assign vsync_rise = vsync_sync_reg[1] & ~vsync_sync_reg[2];

  // Strobe/vsync synchronisers and registered single-cycle write pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      iow_sync_reg   <= 3'b111;
      memw_sync_reg  <= 3'b111;
      ior_sync_reg   <= 2'b11;
      memr_sync_reg  <= 2'b11;
      vsync_sync_reg <= 3'b000;
      settle_reg     <= 2'b00;
      iow_armed_reg  <= 1'b0;
      memw_armed_reg <= 1'b0;
      io_wr_reg      <= 1'b0;
      mem_wr_reg     <= 1'b0;
    end else begin
      iow_sync_reg   <= {iow_sync_reg[1:0], bus.bus_iow_l};
      memw_sync_reg  <= {memw_sync_reg[1:0], bus.bus_memw_l};
      ior_sync_reg   <= {ior_sync_reg[0], bus.bus_ior_l};
      memr_sync_reg  <= {memr_sync_reg[0], bus.bus_memr_l};
      vsync_sync_reg <= {vsync_sync_reg[1:0], vsync_in};
      settle_reg     <= {settle_reg[0], 1'b1};
      iow_armed_reg  <= iow_armed_reg | (settle_reg[1] & iow_sync_reg[1]);
      memw_armed_reg <= memw_armed_reg | (settle_reg[1] & memw_sync_reg[1]);
      io_wr_reg      <= iow_fall;
      mem_wr_reg     <= memw_fall;
    end
  end

  assign io_wr  = io_wr_reg;
  assign mem_wr = mem_wr_reg;

  // Mode and config registers load only in the write-pulse cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg <= CTRL_INIT;
      cfg_reg  <= 2'b00;
    end else if (io_wr_reg) begin
      if (mode_cs) mode_reg <= bus.bus_d;
      if (cfg_cs)  cfg_reg  <= bus.bus_d[1:0];
    end
  end

  assign graphics      = mode_reg[1] & cfg_reg[0];
  assign disp_page     = mode_reg[7] & cfg_reg[1];
  assign video_enabled = mode_reg[3];
  assign blink_enabled = mode_reg[5];
  assign hsync_out     = hsync_in & video_enabled;

  // Next value of each blink counter, wrapping at its period.
  always_comb begin
    cur_cnt_next = (cur_cnt_reg == CUR_LAST) ? '0 : cur_cnt_reg + CUR_W'(1);
    chr_cnt_next = (chr_cnt_reg == CHR_LAST) ? '0 : chr_cnt_reg + CHR_W'(1);
  end

  // Frame counters advance on each vsync rising edge, independent of writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_cnt_reg      <= '0;
      chr_cnt_reg      <= '0;
      cursor_blink_reg <= 1'b0;
      char_blink_reg   <= 1'b0;
    end else if (vsync_rise) begin
      cur_cnt_reg <= cur_cnt_next;
      chr_cnt_reg <= chr_cnt_next;
      if ((cur_cnt_next == CUR_HALF) || (cur_cnt_next == '0))
        cursor_blink_reg <= ~cursor_blink_reg;
      if ((chr_cnt_next == CHR_HALF) || (chr_cnt_next == '0))
        char_blink_reg <= ~char_blink_reg;
    end
  end

  assign cursor_blink = cursor_blink_reg;
  assign char_blink   = char_blink_reg;

  assign status_byte = {~vsync_sync_reg[1], 3'b111, video_in, 2'b00, hsync_in};

  // Read data mux: memory read wins, then status, CRTC data, config readback.
  always_comb begin
    bus.bus_out = 8'h00;
    if (vram_cs & ~bus.bus_memr_l)    bus.bus_out = vram_dout;
    else if (status_cs)               bus.bus_out = status_byte;
    else if (crtc_cs & bus.bus_a[0])  bus.bus_out = crtc_dout;
    else if (cfg_cs)                  bus.bus_out = {6'b000000, cfg_reg};
  end

  assign bus.bus_dir = ((crtc_cs | status_cs | cfg_cs) & ~bus.bus_ior_l)
                     | (vram_cs & ~bus.bus_memr_l);

endmodule

// File: tb/tb_herc_ctrl.sv
// Directed bench for herc_ctrl: one full-featured card and one MDA-only card
// share the same bus stimulus; expectations are queued then compared.
module tb_herc_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] bus_a;
  logic [7:0]  bus_d;
  logic        ior_l, iow_l, memr_l, memw_l, aen;
  logic [7:0]  crtc_dout, vram_dout;
  logic        vsync_in, hsync_in, video_in;

  logic        a_crtc_cs, a_vram_cs, a_io_wr, a_mem_wr, a_graphics, a_disp_page;
  logic        a_video_enabled, a_blink_enabled, a_cursor_blink, a_char_blink, a_hsync_out;
  logic [15:0] a_vram_addr;
  logic        b_crtc_cs, b_vram_cs, b_io_wr, b_mem_wr, b_graphics, b_disp_page;
  logic        b_video_enabled, b_blink_enabled, b_cursor_blink, b_char_blink, b_hsync_out;
  logic [15:0] b_vram_addr;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          pulse_cnt, pulse_at;

  always #5 clk = ~clk;

  herc_ctrl_if isa0 ();
  herc_ctrl_if isa1 ();

  assign isa0.bus_a = bus_a;   assign isa1.bus_a = bus_a;
  assign isa0.bus_d = bus_d;   assign isa1.bus_d = bus_d;
  assign isa0.bus_ior_l = ior_l;   assign isa1.bus_ior_l = ior_l;
  assign isa0.bus_iow_l = iow_l;   assign isa1.bus_iow_l = iow_l;
  assign isa0.bus_memr_l = memr_l; assign isa1.bus_memr_l = memr_l;
  assign isa0.bus_memw_l = memw_l; assign isa1.bus_memw_l = memw_l;
  assign isa0.bus_aen = aen;   assign isa1.bus_aen = aen;

  herc_ctrl dut (
    .clk(clk), .reset(reset), .bus(isa0),
    .crtc_dout(crtc_dout), .vram_dout(vram_dout),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .video_in(video_in),
    .crtc_cs(a_crtc_cs), .vram_cs(a_vram_cs), .vram_addr(a_vram_addr),
    .io_wr(a_io_wr), .mem_wr(a_mem_wr), .graphics(a_graphics), .disp_page(a_disp_page),
    .video_enabled(a_video_enabled), .blink_enabled(a_blink_enabled),
    .cursor_blink(a_cursor_blink), .char_blink(a_char_blink), .hsync_out(a_hsync_out)
  );

  herc_ctrl #(.HGC_EN(0)) dut_mda (
    .clk(clk), .reset(reset), .bus(isa1),
    .crtc_dout(crtc_dout), .vram_dout(vram_dout),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .video_in(video_in),
    .crtc_cs(b_crtc_cs), .vram_cs(b_vram_cs), .vram_addr(b_vram_addr),
    .io_wr(b_io_wr), .mem_wr(b_mem_wr), .graphics(b_graphics), .disp_page(b_disp_page),
    .video_enabled(b_video_enabled), .blink_enabled(b_blink_enabled),
    .cursor_blink(b_cursor_blink), .char_blink(b_char_blink), .hsync_out(b_hsync_out)
  );

  task automatic expect_val(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check_next(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
      $display("check %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [19:0] a, input logic [7:0] d);
    bus_a = a; bus_d = d; aen = 1'b0; iow_l = 1'b0;
    tick(6);
    iow_l = 1'b1;
    tick(4);
  endtask

  initial begin
    reset = 1'b1; bus_a = '0; bus_d = '0; aen = 1'b0;
    ior_l = 1'b1; iow_l = 1'b1; memr_l = 1'b1; memw_l = 1'b1;
    crtc_dout = 8'h5A; vram_dout = 8'hC3;
    vsync_in = 1'b0; hsync_in = 1'b1; video_in = 1'b1;

    // Reset state
    expect_val("reset_io_wr", 0);        expect_val("reset_video_en", 1);
    expect_val("reset_blink_en", 1);     expect_val("reset_graphics", 0);
    expect_val("reset_disp_page", 0);    expect_val("reset_cursor_blink", 0);
    expect_val("reset_char_blink", 0);
    tick(2);
    check_next(a_io_wr);    check_next(a_video_enabled); check_next(a_blink_enabled);
    check_next(a_graphics); check_next(a_disp_page);
    check_next(a_cursor_blink); check_next(a_char_blink);
    reset = 1'b0;
    tick(4);

    // Status read
    bus_a = 20'h003BA; ior_l = 1'b0;
    expect_val("status_read", 8'hF9); expect_val("status_dir", 1); expect_val("hsync_out_on", 1);
    tick(1);
    check_next(isa0.bus_out); check_next(isa0.bus_dir); check_next(a_hsync_out);
    vsync_in = 1'b1;
    expect_val("status_vsync_hi", 8'h79);
    tick(3);
    check_next(isa0.bus_out);
    vsync_in = 1'b0;
    tick(3);

    // CRTC and mode-register reads
    bus_a = 20'h003B5;
    expect_val("crtc_odd_data", 8'h5A); expect_val("crtc_odd_cs", 1); expect_val("crtc_odd_dir", 1);
    tick(1);
    check_next(isa0.bus_out); check_next(a_crtc_cs); check_next(isa0.bus_dir);
    bus_a = 20'h003B4;
    expect_val("crtc_even_data", 8'h00); expect_val("crtc_even_cs", 1);
    tick(1);
    check_next(isa0.bus_out); check_next(a_crtc_cs);
    bus_a = 20'h003B8;
    expect_val("mode_read_data", 8'h00); expect_val("mode_read_dir", 0); expect_val("mode_read_crtc_cs", 0);
    tick(1);
    check_next(isa0.bus_out); check_next(isa0.bus_dir); check_next(a_crtc_cs);
    bus_a = 20'h003B5; aen = 1'b1;
    expect_val("aen_crtc_cs", 0); expect_val("aen_dir", 0);
    tick(1);
    check_next(a_crtc_cs); check_next(isa0.bus_dir);
    aen = 1'b0; ior_l = 1'b1;

    // Mode write with graphics/page1 disallowed, then enable via config
    io_write(20'h003B8, 8'h82);
    expect_val("m82_graphics", 0); expect_val("m82_disp_page", 0);
    expect_val("m82_video_en", 0); expect_val("m82_hsync_out", 0);
    check_next(a_graphics); check_next(a_disp_page); check_next(a_video_enabled); check_next(a_hsync_out);
    io_write(20'h003BF, 8'h03);
    expect_val("cfg3_graphics", 1); expect_val("cfg3_disp_page", 1);
    expect_val("mda_cfg_graphics", 0); expect_val("mda_cfg_disp_page", 0);
    check_next(a_graphics); check_next(a_disp_page); check_next(b_graphics); check_next(b_disp_page);
    bus_a = 20'h003BF; ior_l = 1'b0;
    expect_val("cfg_readback", 8'h03); expect_val("cfg_read_dir", 1);
    expect_val("mda_cfg_readback", 8'h00); expect_val("mda_cfg_dir", 0);
    tick(1);
    check_next(isa0.bus_out); check_next(isa0.bus_dir); check_next(isa1.bus_out); check_next(isa1.bus_dir);
    ior_l = 1'b1;

    // Held write strobe: one pulse at clk 3, data change later ignored
    bus_a = 20'h003B8; bus_d = 8'h08; iow_l = 1'b0;
    pulse_cnt = 0; pulse_at = 0;
    expect_val("hold_pulse_count", 1); expect_val("hold_pulse_at", 3);
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 10) bus_d = 8'h2A;
      if (a_io_wr) begin
        pulse_cnt++;
        if (pulse_at == 0) pulse_at = i;
      end
    end
    iow_l = 1'b1;
    tick(4);
    check_next(pulse_cnt); check_next(pulse_at);
    expect_val("hold_blink_en", 0); expect_val("hold_video_en", 1);
    check_next(a_blink_enabled); check_next(a_video_enabled);

    // Clearing allow_page1 hides the page while mode[7] is retained
    io_write(20'h003B8, 8'h82);
    expect_val("pg_disp_page", 1); check_next(a_disp_page);
    io_write(20'h003BF, 8'h01);
    expect_val("pg_off_disp_page", 0); expect_val("pg_off_graphics", 1);
    check_next(a_disp_page); check_next(a_graphics);
    io_write(20'h003BF, 8'h03);
    expect_val("pg_back_disp_page", 1); check_next(a_disp_page);

    // Memory window
    io_write(20'h003BF, 8'h00);
    bus_a = 20'hB8010; memr_l = 1'b0;
    expect_val("mem_hi_cfg0_cs", 0); expect_val("mem_hi_cfg0_dir", 0);
    expect_val("mem_hi_cfg0_addr", 16'h0010); expect_val("mda_mem_hi_cs", 0);
    tick(1);
    check_next(a_vram_cs); check_next(isa0.bus_dir); check_next(a_vram_addr); check_next(b_vram_cs);
    bus_a = 20'hB0010;
    expect_val("mem_lo_cs", 1); expect_val("mem_lo_data", 8'hC3); expect_val("mem_lo_dir", 1);
    tick(1);
    check_next(a_vram_cs); check_next(isa0.bus_out); check_next(isa0.bus_dir);
    aen = 1'b1;
    expect_val("mem_lo_aen_cs", 1);
    tick(1);
    check_next(a_vram_cs);
    aen = 1'b0; memr_l = 1'b1;
    io_write(20'h003BF, 8'h03);
    bus_a = 20'hB8010; memr_l = 1'b0;
    expect_val("mem_hi_cfg3_cs", 1); expect_val("mem_hi_cfg3_addr", 16'h8010);
    expect_val("mem_hi_cfg3_dir", 1); expect_val("mda_mem_hi_cfg3_cs", 0);
    expect_val("mda_mem_hi_dir", 0); expect_val("mda_mem_hi_addr", 16'h0010);
    tick(1);
    check_next(a_vram_cs); check_next(a_vram_addr); check_next(isa0.bus_dir);
    check_next(b_vram_cs); check_next(isa1.bus_dir); check_next(b_vram_addr);
    memr_l = 1'b1;

    // Memory write strobe
    bus_a = 20'hB0000; memw_l = 1'b0;
    pulse_cnt = 0; pulse_at = 0;
    expect_val("memw_pulse_count", 1); expect_val("memw_pulse_at", 3);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (a_mem_wr) begin
        pulse_cnt++;
        if (pulse_at == 0) pulse_at = i;
      end
    end
    memw_l = 1'b1;
    tick(4);
    check_next(pulse_cnt); check_next(pulse_at);

    // Reset asserted mid-strobe: no write on release
    bus_a = 20'h003B8; bus_d = 8'hFF; iow_l = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    pulse_cnt = 0;
    expect_val("rst_strobe_pulses", 0);
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (a_io_wr) pulse_cnt++;
    end
    iow_l = 1'b1;
    tick(4);
    check_next(pulse_cnt);
    expect_val("rst_strobe_graphics", 0); expect_val("rst_strobe_blink_en", 1);
    expect_val("rst_strobe_disp_page", 0);
    check_next(a_graphics); check_next(a_blink_enabled); check_next(a_disp_page);

    // Blink generators over 32 frames; a mode write mid-run must not disturb them
    for (int f = 1; f <= 32; f++) begin
      vsync_in = 1'b1;
      tick(4);
      vsync_in = 1'b0;
      tick(4);
      if (f == 20) io_write(20'h003B8, 8'h28);
      expect_val($sformatf("cursor_blink_f%0d", f), (f / 8) % 2);
      expect_val($sformatf("char_blink_f%0d", f), (f / 16) % 2);
      check_next(a_cursor_blink);
      check_next(a_char_blink);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
